hazard_ctrl: RTL

Pipeline hazard controller for the five-stage RV32 core: drives the stage enables and flushes consumed by the IF/ID, ID/EX and EX/MEM pipeline registers, and the EX-stage forwarding selects. It detects load-use hazards, squashes wrong-path instructions on taken branches and jumps, and freezes the pipeline while a data-memory access is outstanding. A wait-state FSM with a watchdog tracks memory stalls.

---
 rtl/hazard_ctrl_if.sv | 42 ++++
 rtl/hazard_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side hazard signal bundle: source/dest tags, memory handshake,
// stage enables, flushes and EX forwarding selects.
interface hazard_ctrl_if;
  logic [4:0] Rs1D;
  logic [4:0] Rs2D;
  logic [4:0] Rs1E;
  logic [4:0] Rs2E;
  logic [4:0] RdE;
  logic [4:0] RdM;
  logic [4:0] RdW;
  logic       RegWriteE;
  logic       RegWriteM;
  logic       RegWriteW;
  logic [1:0] ResultSrcE;
  logic       PCSrcE;
  logic       dmem_req;
  logic       dmem_ack;
  logic       EnableF;
  logic       EnableD;
  logic       EnableE;
  logic       EnableM;
  logic       FlushD;
  logic       FlushE;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteE, RegWriteM, RegWriteW, ResultSrcE,
    output PCSrcE, dmem_req, dmem_ack,
    input  EnableF, EnableD, EnableE, EnableM,
    input  FlushD, FlushE, ForwardAE, ForwardBE
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteE, RegWriteM, RegWriteW, ResultSrcE,
    input  PCSrcE, dmem_req, dmem_ack,
    output EnableF, EnableD, EnableE, EnableM,
    output FlushD, FlushE, ForwardAE, ForwardBE
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller: forwarding, load-use stall, branch squash, memory freeze
// with wait watchdog. HAZ_PERF_CNT_EN adds saturating perf counters.
module hazard_ctrl #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic clock,
  input  logic reset,
  hazard_ctrl_if.slave hz,
  output logic mem_timeout
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] loaduse_bubbles,
  output logic [31:0] flush_events
`endif
);

  localparam logic [7:0] LIM = 8'(WAIT_LIMIT);

  typedef enum logic {RUN, WAIT} state_t;

  state_t     state, state_n;
  logic [7:0] wait_cnt, cnt_n;
  logic       mem_stall;
  logic       load_use;
  logic       win_lu;
  logic       win_br;

  function automatic logic [1:0] fwd(
    input logic [4:0] rs,
    input logic       wm,
    input logic [4:0] rdm,
    input logic       ww,
    input logic [4:0] rdw
  );
    if (wm && rdm != 5'd0 && rdm == rs)
      return 2'b10;
    else if (ww && rdw != 5'd0 && rdw == rs)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign hz.ForwardAE = fwd(hz.Rs1E, hz.RegWriteM, hz.RdM,
                            hz.RegWriteW, hz.RdW);
  assign hz.ForwardBE = fwd(hz.Rs2E, hz.RegWriteM, hz.RdM,
                            hz.RegWriteW, hz.RdW);

  assign mem_stall = hz.dmem_req & ~hz.dmem_ack;
  assign load_use  = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                     ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  // Freeze outranks squash: flushing now would clobber the held ID/EX.
  always_comb begin
    hz.EnableF = 1'b1;
    hz.EnableD = 1'b1;
    hz.EnableE = 1'b1;
    hz.EnableM = 1'b1;
    hz.FlushD  = 1'b0;
    hz.FlushE  = 1'b0;
    win_lu     = 1'b0;
    win_br     = 1'b0;
    if (mem_stall) begin
      hz.EnableF = 1'b0;
      hz.EnableD = 1'b0;
      hz.EnableE = 1'b0;
      hz.EnableM = 1'b0;
    end else if (hz.PCSrcE) begin
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
      win_br    = 1'b1;
    end else if (load_use) begin
      hz.EnableF = 1'b0;
      hz.EnableD = 1'b0;
      hz.FlushE  = 1'b1;
      win_lu     = 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = wait_cnt;
    case (state)
      RUN: begin
        if (mem_stall) begin
          state_n = WAIT;
          cnt_n   = 8'd1;
        end
      end
      WAIT: begin
        if (!mem_stall) begin
          state_n = RUN;
          cnt_n   = 8'd0;
        end else if (wait_cnt != 8'hff) begin
          cnt_n = wait_cnt + 8'd1;
        end
      end
      default: begin
        state_n = RUN;
        cnt_n   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      wait_cnt    <= 8'd0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= state_n;
      wait_cnt <= cnt_n;
      if (state_n == WAIT && cnt_n >= LIM)
        mem_timeout <= 1'b1;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles    <= '0;
      loaduse_bubbles <= '0;
      flush_events    <= '0;
    end else begin
      if (mem_stall && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
      if (win_lu && loaduse_bubbles != '1)
        loaduse_bubbles <= loaduse_bubbles + 32'd1;
      if (win_br && flush_events != '1)
        flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule
